cpu_mem_responder: RTL and testbench



---
 rtl/cpu_mem_responder.sv | 135 +++++++++++++
 tb/tb_cpu_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// cpu_mem_responder: dual-port program/data RAM plus LED/cycle/compare/status MMIO
// serving the CPU fetch and load/store ports with 1-cycle read latency. Rev 1.0
module cpu_mem_responder #(
  parameter int          MEM_ADDR_W = 12,
  parameter logic [15:0] MMIO_BASE  = 16'hF000,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_pc_addr,
  input  logic        i_pc_rd,
  output logic [15:0] o_pc_rddata,
  input  logic [15:0] i_ldst_addr,
  input  logic        i_ldst_rd,
  input  logic        i_ldst_wr,
  input  logic [15:0] i_ldst_wrdata,
  output logic [15:0] o_ldst_rddata,
  output logic [15:0] o_leds,
  output logic        o_timer_hit
);

  localparam int         DEPTH      = 1 << MEM_ADDR_W;
  localparam logic [1:0] REG_LED    = 2'd0;
  localparam logic [1:0] REG_CYCLE  = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [15:0]           mem [DEPTH];
  logic [MEM_ADDR_W-1:0] pc_idx;
  logic [MEM_ADDR_W-1:0] ls_idx;
  logic                  pc_mmio;
  logic                  ls_mmio;
  logic                  ls_reg_ok;
  logic [1:0]            ls_reg;
  logic                  ld_en;
  logic                  ram_we;
  logic [15:0]           pc_ram;
  logic [15:0]           ls_ram;

  logic [15:0]           leds;
  logic [15:0]           cycle;
  logic [15:0]           cmp;
  logic                  hit;
  logic [15:0]           mmio_rdata;
  logic                  led_we;
  logic                  cmp_we;
  logic                  status_we;

  logic                  pc_valid;
  logic                  pc_from_mmio;
  logic                  ls_valid;
  logic                  ls_from_mmio;
  logic [15:0]           ls_mmio_data;
  logic                  unused_ok;

  assign pc_idx    = i_pc_addr[MEM_ADDR_W:1];
  assign ls_idx    = i_ldst_addr[MEM_ADDR_W:1];
  assign pc_mmio   = (i_pc_addr[15:12] == MMIO_BASE[15:12]);
  assign ls_mmio   = (i_ldst_addr[15:12] == MMIO_BASE[15:12]);
  assign ls_reg_ok = (i_ldst_addr[11:3] == 9'd0);
  assign ls_reg    = i_ldst_addr[2:1];
  assign unused_ok = ^{i_pc_addr[0], i_ldst_addr[0]};

  // A store wins over a simultaneous load; the load is dropped entirely.
  assign ld_en  = i_ldst_rd & ~i_ldst_wr;
  assign ram_we = i_ldst_wr & ~ls_mmio;

  assign led_we    = i_ldst_wr & ls_mmio & ls_reg_ok & (ls_reg == REG_LED);
  assign cmp_we    = i_ldst_wr & ls_mmio & ls_reg_ok & (ls_reg == REG_CMP);
  assign status_we = i_ldst_wr & ls_mmio & ls_reg_ok & (ls_reg == REG_STATUS);

  // Non-blocking updates give read-first behaviour on same-word fetch/store.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ls_idx] <= i_ldst_wrdata;
    if (i_pc_rd) pc_ram <= mem[pc_idx];
    if (ld_en) ls_ram <= mem[ls_idx];
  end

  always_comb begin
    mmio_rdata = 16'h0000;
    if (ls_reg_ok) begin
      case (ls_reg)
        REG_LED:    mmio_rdata = leds;
        REG_CYCLE:  mmio_rdata = cycle;
        REG_CMP:    mmio_rdata = cmp;
        REG_STATUS: mmio_rdata = {15'd0, hit};
        default:    mmio_rdata = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds  <= 16'h0000;
      cycle <= 16'h0000;
      cmp   <= 16'hFFFF;
      hit   <= 1'b0;
    end else begin
      cycle <= cycle + 16'd1;
      if (led_we) leds <= i_ldst_wrdata;
      if (cmp_we) cmp <= i_ldst_wrdata;
      if (cycle == cmp) hit <= 1'b1;
      else if (status_we && i_ldst_wrdata[0]) hit <= 1'b0;
    end
  end

  // Result-select flags carry the async reset since the RAM read registers cannot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_valid     <= 1'b0;
      pc_from_mmio <= 1'b0;
      ls_valid     <= 1'b0;
      ls_from_mmio <= 1'b0;
      ls_mmio_data <= 16'h0000;
    end else begin
      if (i_pc_rd) begin
        pc_valid     <= 1'b1;
        pc_from_mmio <= pc_mmio;
      end
      if (ld_en) begin
        ls_valid     <= 1'b1;
        ls_from_mmio <= ls_mmio;
        ls_mmio_data <= mmio_rdata;
      end
    end
  end

  assign o_pc_rddata   = (pc_valid && !pc_from_mmio) ? pc_ram : 16'h0000;
  assign o_ldst_rddata = !ls_valid ? 16'h0000 : (ls_from_mmio ? ls_mmio_data : ls_ram);
  assign o_leds        = leds;
  assign o_timer_hit   = hit;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// tb_cpu_mem_responder: directed self-checking bench for cpu_mem_responder. Rev 1.0
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_addr;
  logic        pc_rd;
  logic [15:0] pc_rddata;
  logic [15:0] ldst_addr;
  logic        ldst_rd;
  logic        ldst_wr;
  logic [15:0] ldst_wrdata;
  logic [15:0] ldst_rddata;
  logic [15:0] leds;
  logic        timer_hit;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] mc;
  logic [15:0] exp_v;
  logic [15:0] target;
  int          guard;

  cpu_mem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .i_pc_addr     (pc_addr),
    .i_pc_rd       (pc_rd),
    .o_pc_rddata   (pc_rddata),
    .i_ldst_addr   (ldst_addr),
    .i_ldst_rd     (ldst_rd),
    .i_ldst_wr     (ldst_wr),
    .i_ldst_wrdata (ldst_wrdata),
    .o_ldst_rddata (ldst_rddata),
    .o_leds        (leds),
    .o_timer_hit   (timer_hit)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: value the DUT counter holds between edges.
  always @(posedge clk or posedge reset) begin
    if (reset) mc <= 16'h0000;
    else       mc <= mc + 16'd1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %04h expected %04h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [15:0] a, input logic [15:0] d);
    ldst_addr = a; ldst_wrdata = d; ldst_wr = 1'b1;
    step();
    ldst_wr = 1'b0;
  endtask

  task automatic ld(input logic [15:0] a);
    ldst_addr = a; ldst_rd = 1'b1;
    step();
    ldst_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc_addr = '0; pc_rd = 1'b0;
    ldst_addr = '0; ldst_rd = 1'b0; ldst_wr = 1'b0; ldst_wrdata = '0;
    repeat (2) step();
    check("rst_pc", pc_rddata, 16'h0000);
    check("rst_ld", ldst_rddata, 16'h0000);
    check("rst_leds", leds, 16'h0000);
    check("rst_hit", {15'd0, timer_hit}, 16'h0000);
    @(negedge clk) reset = 1'b0;

    // Timer
    ld(16'hF004);
    check("cmp_rst", ldst_rddata, 16'hFFFF);
    st(16'hF004, 16'h0020);
    exp_v = mc;
    ld(16'hF002);
    check("cycle_sample", ldst_rddata, exp_v);
    guard = 0;
    while (mc != 16'h0020 && guard < 200) begin step(); guard++; end
    check("hit_wait_bound", (guard < 200) ? 16'h0 : 16'h1, 16'h0);
    check("hit_pre", {15'd0, timer_hit}, 16'h0000);
    step();
    check("hit_rise", {15'd0, timer_hit}, 16'h0001);
    repeat (3) step();
    check("hit_sticky", {15'd0, timer_hit}, 16'h0001);
    st(16'hF006, 16'h0000);
    check("hit_w0", {15'd0, timer_hit}, 16'h0001);
    ld(16'hF006);
    check("status_rd", ldst_rddata, 16'h0001);
    st(16'hF006, 16'h0001);
    check("hit_w1c", {15'd0, timer_hit}, 16'h0000);
    target = mc + 16'd8;
    st(16'hF004, target);
    guard = 0;
    while (mc != target && guard < 200) begin step(); guard++; end
    check("match_wait_bound", (guard < 200) ? 16'h0 : 16'h1, 16'h0);
    st(16'hF006, 16'h0001);
    check("hit_set_wins", {15'd0, timer_hit}, 16'h0001);
    st(16'hF006, 16'h0001);
    check("hit_clr2", {15'd0, timer_hit}, 16'h0000);

    // RAM fetch / load / store
    st(16'h0000, 16'h1234);
    st(16'h0002, 16'hABCD);
    pc_addr = 16'h0000; pc_rd = 1'b1;
    step();
    check("fetch0", pc_rddata, 16'h1234);
    pc_addr = 16'h0002;
    step();
    check("fetch2", pc_rddata, 16'hABCD);
    pc_rd = 1'b0;
    step();
    check("fetch_hold", pc_rddata, 16'hABCD);
    st(16'h0010, 16'h5A5A);
    ld(16'h0010);
    check("load_5a5a", ldst_rddata, 16'h5A5A);
    st(16'h2010, 16'h1111);
    ld(16'h0010);
    check("load_alias", ldst_rddata, 16'h1111);
    ld(16'h0011);
    check("load_bit0", ldst_rddata, 16'h1111);

    // Same-word fetch and store: read-first
    pc_addr = 16'h0010; pc_rd = 1'b1;
    ldst_addr = 16'h0010; ldst_wrdata = 16'h7777; ldst_wr = 1'b1;
    step();
    ldst_wr = 1'b0;
    check("coll_old", pc_rddata, 16'h1111);
    step();
    check("coll_new", pc_rddata, 16'h7777);
    pc_rd = 1'b0;

    // Load and store together: store done, load suppressed
    ldst_addr = 16'h0020; ldst_wrdata = 16'hBEEF; ldst_rd = 1'b1; ldst_wr = 1'b1;
    step();
    ldst_rd = 1'b0; ldst_wr = 1'b0;
    check("rdwr_hold", ldst_rddata, 16'h1111);
    ld(16'h0020);
    check("rdwr_write", ldst_rddata, 16'hBEEF);
    step();
    check("load_hold", ldst_rddata, 16'hBEEF);

    // MMIO
    st(16'hF000, 16'h00FF);
    check("leds", leds, 16'h00FF);
    ld(16'hF000);
    check("load_led", ldst_rddata, 16'h00FF);
    pc_addr = 16'hF000; pc_rd = 1'b1;
    step();
    pc_rd = 1'b0;
    check("fetch_mmio", pc_rddata, 16'h0000);
    st(16'hF008, 16'h5555);
    ld(16'hF008);
    check("load_hole", ldst_rddata, 16'h0000);
    st(16'hF002, 16'h1234);
    exp_v = mc;
    ld(16'hF002);
    check("cycle_ro", ldst_rddata, exp_v);

    // Asynchronous reset with a load in flight
    ld(16'hF000);
    check("pre_rst_ld", ldst_rddata, 16'h00FF);
    ldst_addr = 16'h0000; ldst_rd = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("arst_ld", ldst_rddata, 16'h0000);
    check("arst_leds", leds, 16'h0000);
    check("arst_pc", pc_rddata, 16'h0000);
    ldst_rd = 1'b0;
    step();
    @(negedge clk) reset = 1'b0;
    ld(16'hF004);
    check("arst_cmp", ldst_rddata, 16'hFFFF);
    exp_v = mc;
    ld(16'hF002);
    check("arst_cycle", ldst_rddata, exp_v);
    check("arst_cycle_small", (exp_v < 16'd4) ? 16'h0 : 16'h1, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
